mips_mc_ctrl: RTL
=================

Name: mips_mc_ctrl

Overview:
- Multicycle control sequencer for the 8-bit MIPS datapath.
- Fetches a 32-bit instruction as byte-wide instruction-register loads, then decodes the opcode.
- Steps the shared 8-bit ALU, memory, register file and PC through one instruction at a time.
- Drives the ALU's 3-bit alucont and every datapath mux and enable; consumes the ALU zero flag for branches.

Parameters:
- INSTR_BYTES, 4: number of fetch cycles (legal 1..4); fetch cycle k loads IR byte k-1.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  6  instruction opcode from IR[31:26]
- funct  in  6  R-type function from IR[5:0]
- zero  in  1  ALU zero flag
- memread  out  1  memory read enable
- memwrite  out  1  memory write enable
- iord  out  1  memory address select (0 = PC, 1 = ALUOut)
- irwrite  out  4  one-hot IR byte load enable
- alusrca  out  1  ALU A select (0 = PC, 1 = reg A)
- alusrcb  out  2  ALU B select (00 = reg B, 01 = const 1, 10 = imm, 11 = branch offset)
- alucont  out  3  ALU control (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
- pcsource  out  2  PC source (00 = ALU, 01 = ALUOut, 10 = jump target)
- pcen  out  1  PC write enable
- regwrite  out  1  register file write
- regdst  out  1  destination select (0 = rt, 1 = rd)
- memtoreg  out  1  writeback select (0 = ALUOut, 1 = MDR)
- state  out  4  current state code, for debug

Behaviour:
- Reset:
  - reset_n low asynchronously sets state to FETCH1 (code 0).
  - While reset_n is low, every control output is forced to 0, including alucont = 000.
  - Deasserting reset_n mid-instruction restarts at FETCH1.
- Output timing:
  - Outputs are combinational from the state register (Moore).
  - Exception: alucont in RTYPEEX also decodes funct.
  - Any signal not listed for a state is 0; alucont defaults to 010.
- pcen = pcwrite | (pcwritecond & zero).
- State codes: FETCH1..4 = 0..3, DECODE 4, MEMADR 5, LBRD 6, LBWR 7, SBWR 8, RTYPEEX 9, RTYPEWR 10, BEQEX 11, JEX 12, ADDIEX 13, ADDIWR 14, BNEEX 15 (optional feature only).
- FETCHk:
  - memread = 1, irwrite bit k-1 = 1, alusrcb = 01, alucont = 010, pcwrite = 1.
  - Next is FETCH(k+1); after FETCH INSTR_BYTES, next is DECODE.
- DECODE:
  - alusrcb = 11, alucont = 010 (branch target into ALUOut).
  - Next by op: 100000 (LB) or 101000 (SB) to MEMADR; 000000 to RTYPEEX; 000100 to BEQEX; 000010 to JEX; 001000 to ADDIEX.
  - Any other op goes to FETCH1 and is executed as a NOP with no writes.
- MEMADR: alusrca = 1, alusrcb = 10, add. Next is LBRD if op = LB, otherwise SBWR.
- LBRD: memread = 1, iord = 1. Next is LBWR.
- LBWR: regwrite = 1, memtoreg = 1. Next is FETCH1.
- SBWR: memwrite = 1, iord = 1. Next is FETCH1.
- RTYPEEX:
  - alusrca = 1, alusrcb = 00.
  - funct 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111; any other funct gives 010.
  - Next is RTYPEWR.
- RTYPEWR: regdst = 1, regwrite = 1. Next is FETCH1.
- BEQEX: alusrca = 1, alucont = 110, pcwritecond = 1, pcsource = 01. Next is FETCH1.
- JEX: pcwrite = 1, pcsource = 10. Next is FETCH1.
- ADDIEX: alusrca = 1, alusrcb = 10, add. Next is ADDIWR.
- ADDIWR: regwrite = 1. Next is FETCH1.
- Encoding safety: unreachable state codes (15 without the optional feature, or fetch states beyond INSTR_BYTES) output all zeros and return to FETCH1.
- Cycle counts with INSTR_BYTES = 4:
  - LB 8, SB 7, R-type 7, ADDI 7, BEQ 6, J 6.
- At most one of memread/memwrite is high in any cycle, and at most one irwrite bit.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined:
  - op 000101 in DECODE goes to BNEEX.
  - BNEEX: alusrca = 1, alucont = 110, pcsource = 01; pcen = ~zero. Next is FETCH1.
- Undefined:
  - op 000101 is an illegal op (NOP, DECODE goes to FETCH1).
  - State code 15 is unreachable.

Test Plan:
- Reset: hold reset_n = 0 across a clk edge, then release → all outputs 0 during reset; first cycle after release state = 0, memread = 1, irwrite = 0001, pcen = 1.
- R-type SUB: op = 000000, funct = 100010 → states 0,1,2,3,4,9,10,0; alucont = 110 in state 9; regdst = regwrite = 1 in state 10; 7 cycles total.
- LB then SB: op = 100000 → states 4,5,6,7 (iord = 1 and memread = 1 in 6, memtoreg = 1 in 7); then op = 101000 → states 4,5,8 with memwrite = 1 only in 8.
- BEQ: zero = 1 → pcen = 1 and pcsource = 01 in state 11; repeat with zero = 0 → pcen = 0; both cases return to state 0.
- Illegal op 111111 → state 4 goes to 0 with no regwrite/memwrite/pcen pulse; under MIPS_CTRL_BNE_EN, op 000101 with zero = 0 → state 15, pcen = 1.
- Async reset mid-instruction: assert reset_n = 0 between edges while in state 7 → state 0 immediately and regwrite drops without waiting for clk.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multicycle control FSM for the 8-bit MIPS datapath: byte-wise fetch, decode, execute, writeback.
// Optional BNE support is enabled by defining MIPS_CTRL_BNE_EN.
module mips_mc_ctrl #(
    parameter int INSTR_BYTES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucont,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14,
        S_BNEEX   = 4'd15
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [3:0] LAST_FETCH = 4'(INSTR_BYTES - 1);

    function automatic logic [2:0] funct_to_alucont(input logic [5:0] f);
        case (f)
            6'b100000: funct_to_alucont = 3'b010;
            6'b100010: funct_to_alucont = 3'b110;
            6'b100100: funct_to_alucont = 3'b000;
            6'b100101: funct_to_alucont = 3'b001;
            6'b101010: funct_to_alucont = 3'b111;
            default:   funct_to_alucont = 3'b010;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic       pcwrite_s, pcwritecond_s, pcwritecondn_s;
    logic       memread_s, memwrite_s, iord_s, alusrca_s, regwrite_s, regdst_s, memtoreg_s;
    logic [3:0] irwrite_s;
    logic [1:0] alusrcb_s, pcsource_s;
    logic [2:0] alucont_s;

    // State register with asynchronous restart at FETCH1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        state_d        = S_FETCH1;
        pcwrite_s      = 1'b0;
        pcwritecond_s  = 1'b0;
        pcwritecondn_s = 1'b0;
        memread_s      = 1'b0;
        memwrite_s     = 1'b0;
        iord_s         = 1'b0;
        irwrite_s      = 4'b0000;
        alusrca_s      = 1'b0;
        alusrcb_s      = 2'b00;
        alucont_s      = 3'b010;
        pcsource_s     = 2'b00;
        regwrite_s     = 1'b0;
        regdst_s       = 1'b0;
        memtoreg_s     = 1'b0;
        case (state_q)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                if (state_q <= LAST_FETCH) begin
                    memread_s = 1'b1;
                    irwrite_s = 4'b0001 << state_q[1:0];
                    alusrcb_s = 2'b01;
                    pcwrite_s = 1'b1;
                    if (state_q == LAST_FETCH) begin
                        state_d = S_DECODE;
                    end else begin
                        state_d = state_t'(state_q + 4'd1);
                    end
                end else begin
                    // Fetch codes past the configured width are never entered legitimately.
                    alucont_s = 3'b000;
                    state_d   = S_FETCH1;
                end
            end
            S_DECODE: begin
                alusrcb_s = 2'b11;
                case (op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      state_d = S_FETCH1;
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (op == OP_LB) begin
                    state_d = S_LBRD;
                end else begin
                    state_d = S_SBWR;
                end
            end
            S_LBRD: begin
                memread_s = 1'b1;
                iord_s    = 1'b1;
                state_d   = S_LBWR;
            end
            S_LBWR: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
            end
            S_SBWR: begin
                memwrite_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca_s = 1'b1;
                alucont_s = funct_to_alucont(funct);
                state_d   = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BEQEX: begin
                alusrca_s     = 1'b1;
                alucont_s     = 3'b110;
                pcwritecond_s = 1'b1;
                pcsource_s    = 2'b01;
            end
            S_JEX: begin
                pcwrite_s  = 1'b1;
                pcsource_s = 2'b10;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_d   = S_ADDIWR;
            end
            S_ADDIWR: begin
                regwrite_s = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNEEX: begin
                alusrca_s      = 1'b1;
                alucont_s      = 3'b110;
                pcwritecondn_s = 1'b1;
                pcsource_s     = 2'b01;
            end
`endif
            default: begin
                alucont_s = 3'b000;
                state_d   = S_FETCH1;
            end
        endcase
    end

    // Output stage: everything is held at zero while reset is asserted.
    always_comb begin
        if (!reset_n) begin
            memread  = 1'b0;
            memwrite = 1'b0;
            iord     = 1'b0;
            irwrite  = 4'b0000;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            alucont  = 3'b000;
            pcsource = 2'b00;
            pcen     = 1'b0;
            regwrite = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
        end else begin
            memread  = memread_s;
            memwrite = memwrite_s;
            iord     = iord_s;
            irwrite  = irwrite_s;
            alusrca  = alusrca_s;
            alusrcb  = alusrcb_s;
            alucont  = alucont_s;
            pcsource = pcsource_s;
            pcen     = pcwrite_s | (pcwritecond_s & zero) | (pcwritecondn_s & ~zero);
            regwrite = regwrite_s;
            regdst   = regdst_s;
            memtoreg = memtoreg_s;
        end
    end

    assign state = state_q;

endmodule
